// File: rtl/lsu_pkg.sv
// LSU shared types: FSM states, RISC-V load/store width codes
// and the request bundle latched on accept.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side bus interfaces
// for the LSU; master initiates, slave answers.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_we,
    output mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_we,
    input  mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: legality, store strobes and
// replication, load lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  wstrb,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        uns;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    is_b = funct3[1:0] == SB[1:0];
    is_h = funct3[1:0] == SH[1:0];
    is_w = funct3[1:0] == SW[1:0];
    uns  = funct3[2];

    legal = 1'b0;
    unique case (funct3)
      LB:      legal = 1'b1;
      LH:      legal = !off[0];
      LW:      legal = off == 2'b00;
      LBU:     legal = !we;
      LHU:     legal = !we && !off[0];
      default: legal = 1'b0;
    endcase

    wstrb = 4'b0000;
    wlane = wdata;
    unique case (1'b1)
      is_b: begin
        wstrb = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
      end
      is_h: begin
        wstrb = 4'b0011 << {off[1], 1'b0};
        wlane = {2{wdata[15:0]}};
      end
      is_w:    wstrb = 4'b1111;
      default: ;
    endcase
    if (!we) wstrb = 4'b0000;

    b    = rdata[{off, 3'b000} +: 8];
    h    = off[1] ? rdata[31:16] : rdata[15:0];
    rext = rdata;
    unique case (1'b1)
      is_b:    rext = {{24{b[7] & !uns}}, b};
      is_h:    rext = {{16{h[15] & !uns}}, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request, runs a single
// memory handshake with timeout, returns a one-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      reset_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  lsu_req_t      r_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          idle;
  logic          tmo;
  logic          a_we;
  logic [2:0]    a_f3;
  logic [1:0]    a_off;
  logic          legal;
  logic [3:0]    wstrb;
  logic [31:0]   wlane;
  logic [31:0]   rext;

  assign idle = state == IDLE;
  assign tmo  = cnt == LAST;

  // Legality is judged on the live request; lanes on the latched one.
  assign a_we  = idle ? req.req_we : r_q.we;
  assign a_f3  = idle ? req.req_funct3 : r_q.funct3;
  assign a_off = idle ? req.req_addr[1:0] : r_q.addr[1:0];

  lsu_align u_align (
    .we     (a_we),
    .funct3 (a_f3),
    .off    (a_off),
    .wdata  (r_q.wdata),
    .rdata  (mem.mem_rdata),
    .legal  (legal),
    .wstrb  (wstrb),
    .wlane  (wlane),
    .rext   (rext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req.req_valid)
              state_nx = legal ? MEM : RESP;
      MEM:  if (mem.mem_ready || tmo)
              state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req.req_valid) begin
          r_q <= '{we:     req.req_we,
                   funct3: req.req_funct3,
                   addr:   req.req_addr,
                   wdata:  req.req_wdata};
          cnt     <= '0;
          rdata_q <= '0;
          err_q   <= !legal;
        end
        // A late mem_ready still wins over the expiring timer.
        MEM: if (mem.mem_ready) begin
          rdata_q <= r_q.we ? '0 : rext;
        end else if (tmo) begin
          err_q <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req.req_ready   = idle;
    mem.mem_valid   = state == MEM;
    mem.mem_we      = (state == MEM) && r_q.we;
    mem.mem_wstrb   = (state == MEM) ? wstrb : 4'b0000;
    mem.mem_addr    = {r_q.addr[31:2], 2'b00};
    mem.mem_wdata   = wlane;
    req.resp_valid  = state == RESP;
    req.resp_rdata  = (state == RESP) ? rdata_q : '0;
    req.resp_err    = (state == RESP) && err_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a per-cycle expectation queue built
// from an arithmetic model, plus literal checks per vector.
module tb_lsu;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  lsu_req_if rif ();
  lsu_mem_if mif ();

  lsu #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (rif),
    .mem     (mif)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic        mem;
    logic [3:0]  lstrb;
    logic [31:0] lwd;
    logic [31:0] lrd;
    logic        lerr;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        rdy;
    logic        mv;
    logic        mwe;
    logic [3:0]  strb;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        rv;
    logic        rerr;
    logic [31:0] rdata;
  } rec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  rec_t q[$];
  vec_t vec[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] rd, input int dly, input logic mem,
    input logic [3:0] lstrb, input logic [31:0] lwd,
    input logic [31:0] lrd, input logic lerr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rd = rd; v.dly = dly; v.mem = mem; v.lstrb = lstrb;
    v.lwd = lwd; v.lrd = lrd; v.lerr = lerr;
    return v;
  endfunction

  // Expected behaviour from the width/alignment rules in plain arithmetic.
  function automatic void model(
    input vec_t v, output logic lg, output int n,
    output logic [3:0] sb, output logic [31:0] wd,
    output logic [31:0] rd, output logic er);
    int sz;
    int off;
    longint x;
    longint top;
    sz  = (v.f3[1:0] == 2'd0) ? 1 :
          (v.f3[1:0] == 2'd1) ? 2 :
          (v.f3[1:0] == 2'd2) ? 4 : 0;
    off = int'(v.addr % 4);
    lg  = (sz != 0) && (v.f3 != 3'b110) &&
          !(v.we && v.f3[2]) && (off % sz == 0);
    sb  = v.we ? 4'(((1 << sz) - 1) << off) : 4'b0000;
    wd  = (sz == 1) ? (v.wd & 32'hFF) * 32'h01010101 :
          (sz == 2) ? (v.wd & 32'hFFFF) * 32'h00010001 : v.wd;
    x   = longint'(v.rd >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    top = 64'd1 << (8 * sz - 1);
    if (!v.f3[2] && sz < 4 && x >= top) x = x - 2 * top;
    rd  = 32'(x);
    if (!lg) begin
      n = 0; er = 1'b1; rd = '0;
    end else if (v.dly < TO) begin
      n = v.dly + 1; er = 1'b0;
      if (v.we) rd = '0;
    end else begin
      n = TO; er = 1'b1; rd = '0;
    end
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r = '{default: 0};
    r.rdy = 1'b1;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t e;
    e = idle_rec();
    if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
    chk("req_ready", 32'(rif.req_ready), 32'(e.rdy));
    chk("mem_valid", 32'(mif.mem_valid), 32'(e.mv));
    chk("mem_we", 32'(mif.mem_we), 32'(e.mwe));
    chk("mem_wstrb", 32'(mif.mem_wstrb), 32'(e.strb));
    chk("resp_valid", 32'(rif.resp_valid), 32'(e.rv));
    chk("resp_err", 32'(rif.resp_err), 32'(e.rerr));
    chk("resp_rdata", rif.resp_rdata, e.rdata);
    if (e.mv) begin
      chk("mem_addr", mif.mem_addr, e.maddr);
      if (e.mwe) chk("mem_wdata", mif.mem_wdata, e.mwd);
    end
  end

  task automatic run(input vec_t v);
    logic        lg;
    logic        er;
    int          n;
    int          c;
    logic [3:0]  sb;
    logic [31:0] wd;
    logic [31:0] rd;
    rec_t        r;
    model(v, lg, n, sb, wd, rd, er);
    @(posedge clk); #1;
    c = cyc;
    rif.req_valid  = 1'b1;
    rif.req_we     = v.we;
    rif.req_funct3 = v.f3;
    rif.req_addr   = v.addr;
    rif.req_wdata  = v.wd;
    mif.mem_ready  = 1'b1;
    mif.mem_rdata  = v.rd;
    for (int k = 1; k <= n + 1; k++) begin
      r = '{default: 0};
      r.cyc = c + k;
      if (k <= n) begin
        r.mv = 1'b1; r.mwe = v.we; r.strb = sb;
        r.maddr = v.addr & ~32'h3; r.mwd = wd;
      end else begin
        r.rv = 1'b1; r.rerr = er; r.rdata = rd;
      end
      q.push_back(r);
    end
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk); #1;
      rif.req_valid  = (k <= n);
      rif.req_we     = ~v.we;
      rif.req_funct3 = v.f3 ^ 3'b001;
      rif.req_addr   = ~v.addr;
      rif.req_wdata  = ~v.wd;
      mif.mem_ready  = (k <= n) ? (k - 1 == v.dly) : 1'b1;
      #2;
      if (k == 1) begin
        chk("lit_mem_valid", 32'(mif.mem_valid), 32'(v.mem));
        if (v.mem) begin
          chk("lit_wstrb", 32'(mif.mem_wstrb), 32'(v.lstrb));
          if (v.we) chk("lit_wdata", mif.mem_wdata, v.lwd);
        end
      end
      if (k == n + 1) begin
        chk("lit_resp_valid", 32'(rif.resp_valid), 32'd1);
        chk("lit_resp_err", 32'(rif.resp_err), 32'(v.lerr));
        chk("lit_resp_rdata", rif.resp_rdata, v.lrd);
      end
    end
  endtask

  initial begin
    vec.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0,
                     1, 4'hF, 32'hDEADBEEF, 0, 0));
    vec.push_back(mk(0, 3'b000, 32'h203, 0, 32'h80112233, 0,
                     1, 4'h0, 0, 32'hFFFFFF80, 0));
    vec.push_back(mk(0, 3'b100, 32'h203, 0, 32'h80112233, 1,
                     1, 4'h0, 0, 32'h00000080, 0));
    vec.push_back(mk(0, 3'b101, 32'h202, 0, 32'h80112233, 0,
                     1, 4'h0, 0, 32'h00008011, 0));
    vec.push_back(mk(1, 3'b000, 32'h101, 32'hA5, 0, 0,
                     1, 4'h2, 32'hA5A5A5A5, 0, 0));
    vec.push_back(mk(1, 3'b001, 32'h102, 32'h1234, 0, 2,
                     1, 4'hC, 32'h12341234, 0, 0));
    vec.push_back(mk(0, 3'b010, 32'h102, 0, 32'h55555555, 0,
                     0, 4'h0, 0, 0, 1));
    vec.push_back(mk(1, 3'b100, 32'h100, 32'h77, 0, 0,
                     0, 4'h0, 0, 0, 1));
    vec.push_back(mk(0, 3'b010, 32'h104, 0, 32'hCAFEF00D, 2,
                     1, 4'h0, 0, 32'hCAFEF00D, 0));
    vec.push_back(mk(0, 3'b001, 32'h204, 0, 32'h7FFF8001, 1,
                     1, 4'h0, 0, 32'hFFFF8001, 0));
    vec.push_back(mk(0, 3'b010, 32'h300, 0, 32'h12345678, 3,
                     1, 4'h0, 0, 32'h12345678, 0));
    vec.push_back(mk(0, 3'b010, 32'h304, 0, 32'h12345678, 99,
                     1, 4'h0, 0, 0, 1));
    vec.push_back(mk(1, 3'b001, 32'h101, 32'hBEEF, 0, 0,
                     0, 4'h0, 0, 0, 1));
    vec.push_back(mk(0, 3'b011, 32'h100, 0, 32'h11111111, 0,
                     0, 4'h0, 0, 0, 1));
    vec.push_back(mk(1, 3'b000, 32'h103, 32'h1FF, 0, 1,
                     1, 4'h8, 32'hFFFFFFFF, 0, 0));
    vec.push_back(mk(1, 3'b010, 32'h108, 32'h01020304, 0, 99,
                     1, 4'hF, 32'h01020304, 0, 1));

    rif.req_valid  = 1'b0;
    rif.req_we     = 1'b0;
    rif.req_funct3 = 3'b000;
    rif.req_addr   = '0;
    rif.req_wdata  = '0;
    mif.mem_ready  = 1'b0;
    mif.mem_rdata  = '0;

    #1 reset_n = 1'b0;
    #2;
    chk("por_mem_valid", 32'(mif.mem_valid), 32'd0);
    chk("por_mem_we", 32'(mif.mem_we), 32'd0);
    chk("por_mem_wstrb", 32'(mif.mem_wstrb), 32'd0);
    chk("por_mem_addr", mif.mem_addr, 32'd0);
    chk("por_resp_valid", 32'(rif.resp_valid), 32'd0);
    chk("por_resp_err", 32'(rif.resp_err), 32'd0);
    chk("por_resp_rdata", rif.resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vec[i]) run(vec[i]);

    @(posedge clk); #1;
    rif.req_valid  = 1'b1;
    rif.req_we     = 1'b0;
    rif.req_funct3 = 3'b010;
    rif.req_addr   = 32'h400;
    mif.mem_ready  = 1'b0;
    @(posedge clk); #1;
    rif.req_valid  = 1'b0;
    chk("rst_pre_mem_valid", 32'(mif.mem_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mem_valid", 32'(mif.mem_valid), 32'd0);
    chk("rst_mem_addr", mif.mem_addr, 32'd0);
    chk("rst_resp_valid", 32'(rif.resp_valid), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(rif.req_ready), 32'd1);
    repeat (6) @(posedge clk);

    run(vec[0]);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
